// File: rtl/ysyx_25040109_trap_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, mstatus
// field positions and the sequencer state encoding.
package ysyx_25040109_trap_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  typedef enum logic [2:0] {
    StIdle,
    StTMepc,
    StTMcause,
    StTMstat,
    StTRedir,
    StRMstat,
    StRRedir
  } trap_state_e;

endpackage

// File: rtl/ysyx_25040109_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry and mret; only MIE, MPIE and MPP
// change, every other bit passes through.
module ysyx_25040109_mstatus_upd
  import ysyx_25040109_trap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic                  is_mret,
  output logic [DATA_WIDTH-1:0] new_val
);

  always_comb begin
    new_val = old_val;
    new_val[MstatusMppHi:MstatusMppLo] = 2'b11;
    if (is_mret) begin
      new_val[MstatusMie]  = old_val[MstatusMpie];
      new_val[MstatusMpie] = 1'b1;
    end else begin
      new_val[MstatusMpie] = old_val[MstatusMie];
      new_val[MstatusMie]  = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_25040109_trap_ctrl.sv
// Trap/mret sequencer: serialises mepc/mcause/mstatus updates onto the single
// CSR write port, then redirects fetch. Arbitrates the port with CSR instructions.
module ysyx_25040109_trap_ctrl
  import ysyx_25040109_trap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_req,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  mret_req,
  input  logic                  inst_csr_we,
  input  logic [11:0]           inst_csr_addr,
  input  logic [DATA_WIDTH-1:0] inst_csr_wdata,
  output logic                  inst_csr_gnt,
  output logic                  csr_we,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic [DATA_WIDTH-1:0] mtvec_in,
  input  logic [DATA_WIDTH-1:0] mepc_in,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  trap_state_e           state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic [DATA_WIDTH-1:0] mstatus_new;

  // Only direct mode is supported, so the mode bits of mtvec are dropped.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_in[1:0];

  ysyx_25040109_mstatus_upd #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mstatus_upd (
    .old_val(csr_rdata),
    .is_mret(state_q == StRMstat),
    .new_val(mstatus_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trap_req) begin
            state_q <= StTMepc;
            pc_q    <= trap_pc;
            cause_q <= trap_cause;
          end else if (mret_req) begin
            state_q <= StRMstat;
          end
        end
        StTMepc:   state_q <= StTMcause;
        StTMcause: state_q <= StTMstat;
        StTMstat:  state_q <= StTRedir;
        StTRedir:  state_q <= StIdle;
        StRMstat:  state_q <= StRRedir;
        StRRedir:  state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Outputs are gated by rst so the port is quiet for the whole reset cycle.
  always_comb begin
    inst_csr_gnt   = 1'b0;
    csr_we         = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;
    if (!rst) begin
      busy = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (inst_csr_we && !trap_req && !mret_req) begin
            inst_csr_gnt = 1'b1;
            csr_we       = 1'b1;
            csr_addr     = inst_csr_addr;
            csr_wdata    = inst_csr_wdata;
          end
        end
        StTMepc: begin
          csr_we    = 1'b1;
          csr_addr  = CsrMepc;
          csr_wdata = pc_q;
        end
        StTMcause: begin
          csr_we    = 1'b1;
          csr_addr  = CsrMcause;
          csr_wdata = cause_q;
        end
        StTMstat, StRMstat: begin
          csr_we    = 1'b1;
          csr_addr  = CsrMstatus;
          csr_wdata = mstatus_new;
        end
        StTRedir: begin
          redirect_valid = 1'b1;
          redirect_pc    = {mtvec_in[DATA_WIDTH-1:2], 2'b00};
        end
        StRRedir: begin
          redirect_valid = 1'b1;
          redirect_pc    = mepc_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_trap_ctrl.sv
// Bench for the trap sequencer: directed scenarios plus random traffic, checked
// each cycle against a model that replays a queue of expected CSR/fetch effects.
module tb_ysyx_25040109_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_req = 1'b0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_pc = '0;
  logic        mret_req = 1'b0;
  logic        inst_csr_we = 1'b0;
  logic [11:0] inst_csr_addr = '0;
  logic [31:0] inst_csr_wdata = '0;
  logic        inst_csr_gnt;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec_v = '0;
  logic [31:0] mepc_v = '0;
  logic [31:0] mstatus_v = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  always #5 clk = ~clk;

  assign csr_rdata = (csr_addr == 12'h300) ? mstatus_v : 32'h0;

  ysyx_25040109_trap_ctrl #(
    .DATA_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trap_req      (trap_req),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .mret_req      (mret_req),
    .inst_csr_we   (inst_csr_we),
    .inst_csr_addr (inst_csr_addr),
    .inst_csr_wdata(inst_csr_wdata),
    .inst_csr_gnt  (inst_csr_gnt),
    .csr_we        (csr_we),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_rdata     (csr_rdata),
    .mtvec_in      (mtvec_v),
    .mepc_in       (mepc_v),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  // Pending effects of an accepted trap/mret, one per upcoming cycle.
  typedef enum int {WrMepc, WrMcause, WrMstatTrap, RedirTrap, WrMstatMret, RedirMret} act_e;
  act_e        plan[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_cause = '0;

  int passes = 0;
  int total  = 0;

  logic        o_we, o_rv, o_busy, o_gnt;
  logic [11:0] o_addr;
  logic [31:0] o_wdata, o_rpc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    return (m & ~32'h1888) | 32'h1800 | (((m >> 3) & 32'h1) << 7);
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    return (m & ~32'h1888) | 32'h1880 | (((m >> 7) & 32'h1) << 3);
  endfunction

  // One clock: compare at negedge against the model, then advance the model.
  task automatic cyc();
    logic        e_we, e_rv, e_busy, e_gnt;
    logic [11:0] e_addr;
    logic [31:0] e_wdata, e_rpc;
    @(negedge clk);
    e_we = 0; e_rv = 0; e_busy = 0; e_gnt = 0; e_addr = 0; e_wdata = 0; e_rpc = 0;
    if (!rst) begin
      if (plan.size() == 0) begin
        if (inst_csr_we && !trap_req && !mret_req) begin
          e_gnt = 1; e_we = 1; e_addr = inst_csr_addr; e_wdata = inst_csr_wdata;
        end
      end else begin
        e_busy = 1;
        case (plan[0])
          WrMepc:      begin e_we = 1; e_addr = 12'h341; e_wdata = m_pc; end
          WrMcause:    begin e_we = 1; e_addr = 12'h342; e_wdata = m_cause; end
          WrMstatTrap: begin e_we = 1; e_addr = 12'h300; e_wdata = trap_mstatus(mstatus_v); end
          WrMstatMret: begin e_we = 1; e_addr = 12'h300; e_wdata = mret_mstatus(mstatus_v); end
          RedirTrap:   begin e_rv = 1; e_rpc = mtvec_v & ~32'h3; end
          RedirMret:   begin e_rv = 1; e_rpc = mepc_v; end
          default: ;
        endcase
      end
    end
    o_we = csr_we; o_addr = csr_addr; o_wdata = csr_wdata; o_rv = redirect_valid;
    o_rpc = redirect_pc; o_busy = busy; o_gnt = inst_csr_gnt;
    chk("csr_we", 32'(o_we), 32'(e_we));
    chk("csr_addr", 32'(o_addr), 32'(e_addr));
    chk("csr_wdata", o_wdata, e_wdata);
    chk("redirect_valid", 32'(o_rv), 32'(e_rv));
    chk("redirect_pc", o_rpc, e_rpc);
    chk("busy", 32'(o_busy), 32'(e_busy));
    chk("inst_csr_gnt", 32'(o_gnt), 32'(e_gnt));
    @(posedge clk);
    if (rst) begin
      plan.delete();
      m_pc = 0;
      m_cause = 0;
    end else if (plan.size() != 0) begin
      void'(plan.pop_front());
    end else if (trap_req) begin
      plan = '{WrMepc, WrMcause, WrMstatTrap, RedirTrap};
      m_pc = trap_pc;
      m_cause = trap_cause;
    end else if (mret_req) begin
      plan = '{WrMstatMret, RedirMret};
    end
    #1;
  endtask

  int redirs;
  int busy_cycles;

  initial begin
    #1;
    rst = 1; cyc(); cyc();
    rst = 0; cyc();

    // Basic trap entry.
    mstatus_v = 32'h8; mtvec_v = 32'h8000_0100;
    trap_req = 1; trap_pc = 32'h8000_0010; trap_cause = 32'd11; cyc();
    trap_req = 0; trap_pc = 32'hffff_fff0; trap_cause = 32'h5;
    busy_cycles = 0;
    cyc(); busy_cycles += int'(o_busy);
    chk("t_mepc_addr", 32'(o_addr), 32'h341); chk("t_mepc_data", o_wdata, 32'h8000_0010);
    cyc(); busy_cycles += int'(o_busy);
    chk("t_mcause_addr", 32'(o_addr), 32'h342); chk("t_mcause_data", o_wdata, 32'hb);
    cyc(); busy_cycles += int'(o_busy);
    chk("t_mstat_addr", 32'(o_addr), 32'h300); chk("t_mstat_data", o_wdata, 32'h1880);
    cyc(); busy_cycles += int'(o_busy);
    chk("t_redir_pc", o_rpc, 32'h8000_0100);
    cyc(); busy_cycles += int'(o_busy);
    chk("t_busy_cycles", busy_cycles, 4);

    // mret.
    mstatus_v = 32'h1880; mepc_v = 32'h8000_0014;
    mret_req = 1; cyc();
    mret_req = 0;
    cyc(); chk("r_mstat_data", o_wdata, 32'h1888); chk("r_mstat_busy", 32'(o_busy), 1);
    cyc(); chk("r_redir_pc", o_rpc, 32'h8000_0014);
    cyc(); chk("r_idle_busy", 32'(o_busy), 0);

    // Simultaneous trap+mret, then trap held high while busy.
    mstatus_v = 32'h0; redirs = 0;
    trap_req = 1; mret_req = 1; trap_pc = 32'h100; trap_cause = 32'h2; cyc();
    mret_req = 0;
    cyc(); chk("both_first_write", 32'(o_addr), 32'h341); redirs += int'(o_rv);
    cyc(); redirs += int'(o_rv);
    cyc(); redirs += int'(o_rv);
    trap_req = 0;
    cyc(); redirs += int'(o_rv);
    cyc(); redirs += int'(o_rv);
    chk("single_redirect", redirs, 1);

    // CSR instruction passthrough and arbitration against trap_req.
    mtvec_v = 32'h8000_0100;
    inst_csr_we = 1; inst_csr_addr = 12'h305; inst_csr_wdata = 32'h8000_0103; cyc();
    chk("inst_gnt", 32'(o_gnt), 1); chk("inst_wdata", o_wdata, 32'h8000_0103);
    trap_req = 1; trap_pc = 32'h200; trap_cause = 32'h3; cyc();
    chk("inst_gnt_blocked", 32'(o_gnt), 0);
    trap_req = 0; inst_csr_we = 0; mtvec_v = 32'h8000_0103;
    cyc(); cyc(); cyc(); cyc();
    chk("masked_mtvec", o_rpc, 32'h8000_0100);
    cyc();

    // Reset in the middle of a trap sequence.
    trap_req = 1; trap_pc = 32'h300; trap_cause = 32'h7; cyc();
    trap_req = 0; cyc();
    rst = 1; cyc(); chk("rst_mid_we", 32'(o_we), 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("after_rst_we", 32'(o_we), 0);
      chk("after_rst_rv", 32'(o_rv), 0);
    end
    trap_req = 1; trap_pc = 32'h400; trap_cause = 32'h8; cyc();
    trap_req = 0;
    for (int i = 0; i < 4; i++) cyc();
    chk("fresh_trap_redir", 32'(o_rv), 1);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(39) == 0);
      trap_req = ($urandom_range(7) == 0);
      mret_req = ($urandom_range(7) == 0);
      trap_pc = $urandom(); trap_cause = $urandom();
      inst_csr_we = $urandom_range(1) == 1;
      inst_csr_addr = 12'($urandom()); inst_csr_wdata = $urandom();
      mstatus_v = $urandom(); mtvec_v = $urandom(); mepc_v = $urandom();
      cyc();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/ysyx_25040109_trap_ctrl.md
YSYX_25040109_TRAP_CTRL -- requirements
Module: ysyx_25040109_trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, CSR/PC datapath width.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports trap_req in 1 (ecall/exception request), trap_cause in DATA_WIDTH (mcause value), trap_pc in DATA_WIDTH (faulting PC).
REQ-005 SHALL have port mret_req  in  1  mret request.
REQ-006 SHALL have ports inst_csr_we in 1, inst_csr_addr in 12, inst_csr_wdata in DATA_WIDTH (CSR-instruction write request); inst_csr_gnt out 1 (request forwarded this cycle).
REQ-007 SHALL have ports csr_we out 1, csr_addr out 12, csr_wdata out DATA_WIDTH (shared CSR file write port); csr_rdata in DATA_WIDTH (combinational read of csr_addr).
REQ-008 SHALL have ports mtvec_in, mepc_in  in  DATA_WIDTH  current mtvec/mepc register values.
REQ-009 SHALL have ports redirect_valid out 1, redirect_pc out DATA_WIDTH (PC override to fetch); busy out 1 (core SHALL stall while high).

Function
REQ-010 SHALL implement FSM states IDLE, T_MEPC, T_MCAUSE, T_MSTAT, T_REDIR, R_MSTAT, R_REDIR.
REQ-011 IDLE: trap_req -> T_MEPC; else mret_req -> R_MSTAT; trap_req wins when both high.
REQ-012 On trap acceptance SHALL latch trap_pc and trap_cause; later input changes ignored.
REQ-013 Trap sequence: T_MEPC -> T_MCAUSE -> T_MSTAT -> T_REDIR -> IDLE, one cycle each (4 cycles busy).
REQ-014 mret sequence: R_MSTAT -> R_REDIR -> IDLE (2 cycles busy).
REQ-015 T_MEPC: csr_we=1, csr_addr=0x341, csr_wdata=latched pc.
REQ-016 T_MCAUSE: csr_we=1, csr_addr=0x342, csr_wdata=latched cause.
REQ-017 T_MSTAT: csr_addr=0x300, csr_we=1, csr_wdata=csr_rdata with MPIE(bit7)<=MIE(bit3), MIE<=0, MPP[12:11]<=2'b11, all other bits preserved (same-cycle read-modify-write).
REQ-018 R_MSTAT: csr_addr=0x300, csr_we=1, csr_wdata=csr_rdata with MIE<=MPIE, MPIE<=1, MPP<=2'b11, others preserved.
REQ-019 T_REDIR: redirect_valid=1, redirect_pc={mtvec_in[DATA_WIDTH-1:2],2'b00} (direct mode only); R_REDIR: redirect_valid=1, redirect_pc=mepc_in.
REQ-020 redirect_valid SHALL be high for exactly one cycle per sequence; redirect_pc=0 when redirect_valid low.
REQ-021 busy SHALL be high in every non-IDLE state, low in IDLE.
REQ-022 inst_csr_gnt = IDLE & !trap_req & !mret_req & inst_csr_we; when granted, csr_* SHALL equal inst_csr_* that cycle.
REQ-023 In IDLE without grant csr_we=0, csr_addr=0, csr_wdata=0; inst CSR requests outside IDLE are not granted (requester retries).
REQ-024 trap_req/mret_req outside IDLE SHALL be ignored; no queuing.
REQ-025 Outputs SHALL be decoded from state and latched registers only (plus combinational csr_rdata/mtvec_in/mepc_in/grant path); no combinational path from trap_req to csr_we.

Reset
REQ-026 rst high at a clock edge SHALL force IDLE and clear latched pc/cause to 0, including mid-sequence (remaining CSR writes abandoned).
REQ-027 While rst high: csr_we=0, inst_csr_gnt=0, redirect_valid=0, redirect_pc=0, busy=0, csr_addr=0, csr_wdata=0.

Structure
REQ-028 Package ysyx_25040109_trap_pkg SHALL hold CSR addresses (0x300,0x305,0x341,0x342), mstatus bit positions (MIE=3, MPIE=7, MPP=12:11), state enum.
REQ-029 One sub-module ysyx_25040109_mstatus_upd SHALL compute trap/mret mstatus values combinationally (inputs: old value, is_mret).
REQ-030 No CSR storage inside this block; register file remains the sole owner.

Verification
REQ-031 Reset, then trap_req with pc=0x80000010, cause=11, mstatus=0x8 -> writes 0x341<=0x80000010, 0x342<=0xB, 0x300<=0x1880 on consecutive cycles, then redirect_pc=mtvec (0x80000100) for one cycle, busy 4 cycles.
REQ-032 mret with mstatus=0x1880, mepc=0x80000014 -> 0x300<=0x1888, then redirect_pc=0x80000014; busy 2 cycles.
REQ-033 trap_req and mret_req same cycle -> trap sequence only; second trap_req during busy -> ignored, one redirect.
REQ-034 inst_csr_we to 0x305 with wdata 0x80000103 while IDLE and no request -> gnt=1, passthrough; same with trap_req high -> gnt=0, trap proceeds; next trap redirects to 0x80000100.
REQ-035 rst asserted in T_MCAUSE -> next cycle IDLE, no mstatus write, no redirect; fresh trap afterwards completes normally.
